padding_frame_ctrl: RTL
=======================

Name: padding_frame_ctrl

Overview:
- Frame sequencer in front of the row-padding datapath.
- Accepts a pixel stream over a valid/ready handshake and re-times it into the line-periodic form the padding stage needs: WIDTH active slots plus HBLANK blanking cycles per row, over DEPTH rows.
- After the last input row, runs an N-row flush phase so the padding delay lines emit the bottom pad rows, then a tail phase, then signals frame completion.
- Drives the padding stage's start, data_en, delay_start and pixel inputs.

Parameters:
- DATA_WIDTH, 16: pixel width.
- WIDTH, 640: active pixels per row.
- DEPTH, 504: input rows per frame.
- N, 4: pad rows (flush length in line periods).
- HBLANK, 80: blanking cycles per line.
- TAIL, 16: idle cycles after flush before frame_done.
- CNT_W, 10: row/column counter width; must hold max(WIDTH+HBLANK, DEPTH+N).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  pulse; begins a frame when idle.
- abort  in  1  synchronous frame abort.
- pix_valid  in  1  upstream pixel valid.
- pix_data  in  DATA_WIDTH  upstream pixel.
- pix_ready  out  1  controller accepts pixel this cycle (combinational from state/counters).
- pad_start  out  1  to padding start.
- pad_data_en  out  1  to padding data_en.
- pad_delay_start  out  1  to padding delay_start.
- pad_data  out  DATA_WIDTH  to padding fmap_raw.
- busy  out  1  high in any non-IDLE state.
- frame_done  out  1  one-cycle completion pulse.
- row_idx  out  CNT_W  current line index.
- col_idx  out  CNT_W  current line-period position.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; all outputs 0; counters 0. Same on abort=1, except abort has no effect in IDLE.
- Priority: rst > abort > normal operation.
- States and transitions:
  - IDLE -> ACTIVE on frame_start=1. frame_start in any other state is ignored.
  - ACTIVE: row 0..DEPTH-1.
    - col 0..WIDTH-1 is the data window. pix_ready=1 only in ACTIVE with col<WIDTH. col increments only on accept (pix_valid&pix_ready), so an upstream stall stretches the line.
    - col WIDTH..WIDTH+HBLANK-1 is blanking. col increments every cycle; pix_ready=0.
    - At col=WIDTH+HBLANK-1: col->0, row+1. After row DEPTH-1 wraps, go to FLUSH with row=0, col=0.
  - FLUSH: free-running col over WIDTH+HBLANK cycles per line, for N lines. pix_ready=0. After the last cycle of line N-1, go to TAIL.
  - TAIL: count TAIL cycles, then go to IDLE and pulse frame_done for exactly 1 cycle (registered, in the first IDLE cycle).
- Outputs, all registered (1-cycle latency from the state/counter that causes them):
  - pad_start=1 in the cycles following ACTIVE entry through the last ACTIVE cycle; 0 otherwise.
  - pad_data_en=1 exactly one cycle after each accept. pad_data=pix_data captured at the accept; pad_data holds its last value when pad_data_en=0.
  - pad_delay_start=1 one cycle after ACTIVE exit, for all of FLUSH; drops one cycle after FLUSH exit. Never high together with pad_start.
  - row_idx and col_idx are the current counters, unregistered copies.
- Accept count per frame is exactly WIDTH*DEPTH.
- Blanking length is independent of stalls.
- pix_valid is don't-care outside the data window.

Test Plan (WIDTH=8, DEPTH=4, N=2, HBLANK=3, TAIL=4):
1. Reset release, frame_start pulse, pix_valid held 1 -> pix_ready high 8 cycles, low 3, repeated 4x. pad_data_en high 32 cycles total, delayed 1 from each accept. pad_data equals the input sequence.
2. Continuation of 1 -> pad_start falls; next cycle pad_delay_start high for exactly 2*11=22 cycles. Then 4 TAIL cycles, then a single frame_done pulse; busy=0 after.
3. pix_valid low for 5 cycles at row 1 col 3 -> col_idx holds at 3 for 5 cycles. Blanking still 3 cycles. Total accepts still 32.
4. frame_start asserted during ACTIVE and FLUSH -> ignored: no counter reset, no second frame.
5. abort at row 2 col 5 -> next cycle IDLE: all outputs 0, no frame_done. A subsequent frame_start runs a full clean frame matching scenario 1.
6. rst asserted mid-FLUSH -> next cycle all outputs and counters 0. Reset is synchronous: rst pulsed between clock edges has no effect.

Source files
------------

// File: rtl/padding_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : padding_frame_ctrl
// Purpose  : Frame sequencer that turns a valid/ready pixel stream into the
//            line-periodic drive of the row-padding stage. It handles the data
//            rows, then the flush rows, then the tail before frame completion.
// Revision : 1.0 - initial release
// ============================================================================
module padding_frame_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int WIDTH      = 640,
    parameter int DEPTH      = 504,
    parameter int N          = 4,
    parameter int HBLANK     = 80,
    parameter int TAIL       = 16,
    parameter int CNT_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  abort,
    input  logic                  pix_valid,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_ready,
    output logic                  pad_start,
    output logic                  pad_data_en,
    output logic                  pad_delay_start,
    output logic [DATA_WIDTH-1:0] pad_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic [CNT_W-1:0]      row_idx,
    output logic [CNT_W-1:0]      col_idx
);

    localparam logic [CNT_W-1:0] WIDTH_C    = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] LINE_LAST  = CNT_W'(WIDTH + HBLANK - 1);
    localparam logic [CNT_W-1:0] DEPTH_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] N_LAST     = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(TAIL - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2,
        S_TAIL   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
    logic             accept;
    logic             col_adv;
    logic             line_end;

    assign pix_ready = (state == S_ACTIVE) && (col < WIDTH_C);
    assign accept    = pix_valid && pix_ready;
    // Inside the data window the column only moves on an accepted pixel,
    // so upstream stalls stretch the line without shortening the blanking.
    assign col_adv   = (col < WIDTH_C) ? accept : 1'b1;
    assign line_end  = (col == LINE_LAST);
    assign busy      = (state != S_IDLE);
    assign row_idx   = row;
    assign col_idx   = col;

    always_ff @(posedge clk) begin
        if (rst || (abort && state != S_IDLE)) begin
            state           <= S_IDLE;
            row             <= '0;
            col             <= '0;
            pad_start       <= 1'b0;
            pad_data_en     <= 1'b0;
            pad_delay_start <= 1'b0;
            pad_data        <= '0;
            frame_done      <= 1'b0;
        end else begin
            pad_start       <= (state == S_ACTIVE);
            pad_delay_start <= (state == S_FLUSH);
            pad_data_en     <= accept;
            frame_done      <= 1'b0;
            if (accept) begin
                pad_data <= pix_data;
            end

            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        state <= S_ACTIVE;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                S_ACTIVE: begin
                    if (col_adv) begin
                        if (line_end) begin
                            col <= '0;
                            if (row == DEPTH_LAST) begin
                                row   <= '0;
                                state <= S_FLUSH;
                            end else begin
                                row <= row + ONE;
                            end
                        end else begin
                            col <= col + ONE;
                        end
                    end
                end
                S_FLUSH: begin
                    if (line_end) begin
                        col <= '0;
                        if (row == N_LAST) begin
                            row   <= '0;
                            state <= S_TAIL;
                        end else begin
                            row <= row + ONE;
                        end
                    end else begin
                        col <= col + ONE;
                    end
                end
                S_TAIL: begin
                    if (col == TAIL_LAST) begin
                        col        <= '0;
                        state      <= S_IDLE;
                        frame_done <= 1'b1;
                    end else begin
                        col <= col + ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
